// File: rtl/cic_decim_mc.sv
// Multi-channel PDM CIC decimator: per-channel integrators,
// shared time-multiplexed comb, buffered output with handshake.
module cic_decim_mc #(
    parameter int N  = 3,
    parameter int R  = 64,
    parameter int CH = 2,
    parameter int OW = 16,
    localparam int W  = N * $clog2(R) + 2,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pdm_en,
    input  logic [CH-1:0] pdm_in,
    output logic [OW-1:0] dout,
    output logic [CW-1:0] dout_ch,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          overrun
);
    localparam int RW = $clog2(R);

    typedef enum logic {
        S_IDLE,
        S_COMB
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] cnt_q;
    logic [CW-1:0] seq_q;
    logic [CW-1:0] ptr_q;
    logic          valid_q;
    logic          ovr_q;

    logic [W-1:0]  integ_q [CH][N];
    logic [W-1:0]  integ_d [CH][N];
    logic [W-1:0]  snap_q  [CH];
    logic [W-1:0]  dly_q   [CH][N];
    logic [W-1:0]  dly_d   [N];
    logic [OW-1:0] obuf_q  [CH];

    logic [W-1:0]  acc;
    logic [W-1:0]  cv;
    logic          tick;
    logic          last_seq;
    logic          last_ptr;
    logic          hs;

    assign tick     = pdm_en && (cnt_q == RW'(R - 1));
    assign last_seq = (seq_q == CW'(CH - 1));
    assign last_ptr = (ptr_q == CW'(CH - 1));
    assign hs       = valid_q && dout_ready;

    // Integrator cascade uses the freshly updated upstream value,
    // so the last stage already contains the current sample.
    always_comb begin
        acc = '0;
        for (int c = 0; c < CH; c++) begin
            acc = integ_q[c][0] + (pdm_in[c] ? W'(1) : {W{1'b1}});
            integ_d[c][0] = acc;
            for (int k = 1; k < N; k++) begin
                acc = integ_q[c][k] + acc;
                integ_d[c][k] = acc;
            end
        end
    end

    always_comb begin
        cv = snap_q[seq_q];
        for (int k = 0; k < N; k++) begin
            dly_d[k] = cv;
            cv = cv - dly_q[seq_q][k];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (tick) state_d = S_COMB;
            S_COMB: if (last_seq) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                snap_q[c] <= '0;
                obuf_q[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    integ_q[c][k] <= '0;
                    dly_q[c][k]   <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (pdm_en) begin
                cnt_q <= cnt_q + 1'b1;
                for (int c = 0; c < CH; c++)
                    for (int k = 0; k < N; k++)
                        integ_q[c][k] <= integ_d[c][k];
            end
            if (tick) begin
                for (int c = 0; c < CH; c++)
                    snap_q[c] <= integ_d[c][N-1];
            end
            if (tick)
                seq_q <= '0;
            else if (state_q == S_COMB)
                seq_q <= seq_q + 1'b1;
            if (state_q == S_COMB) begin
                for (int k = 0; k < N; k++)
                    dly_q[seq_q][k] <= dly_d[k];
                obuf_q[seq_q] <= cv[W-1 -: OW];
            end
            // A frame that is still being drained gets replaced.
            if (state_q == S_COMB && last_seq) begin
                valid_q <= 1'b1;
                ptr_q   <= '0;
                if (valid_q && !(hs && last_ptr))
                    ovr_q <= 1'b1;
            end else if (hs) begin
                if (last_ptr) begin
                    valid_q <= 1'b0;
                    ptr_q   <= '0;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
            end
        end
    end

    assign dout       = obuf_q[ptr_q];
    assign dout_ch    = ptr_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/cic_decim_mc.md
CIC_DECIM_MC -- requirements
Module: cic_decim_mc

Interface
REQ-001 SHALL provide parameter N, default 3, CIC order (integrator/comb stage count), legal 1..6.
REQ-002 SHALL provide parameter R, default 64, decimation ratio, power of two, legal 4..256, R >= CH+2.
REQ-003 SHALL provide parameter CH, default 2, PDM channel count, legal 1..8.
REQ-004 SHALL provide parameter OW, default 16, output word width, legal 8..W.
REQ-005 SHALL use derived constants W = N*log2(R)+2 (internal datapath width) and CW = max(1,clog2(CH)).
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 pdm_en  input  1  sample strobe; one PDM bit per channel consumed per clk with pdm_en=1.
REQ-009 pdm_in  input  CH  PDM bits, bit c = channel c.
REQ-010 dout  output  OW  signed decimated sample.
REQ-011 dout_ch  output  CW  channel index of dout.
REQ-012 dout_valid  output  1  dout/dout_ch hold a valid sample.
REQ-013 dout_ready  input  1  consumer accepts sample when dout_valid&&dout_ready.
REQ-014 overrun  output  1  sticky, a frame was overwritten before fully drained.

Function
REQ-015 Each PDM bit SHALL map to signed W-bit +1 (bit=1) or -1 (bit=0).
REQ-016 Per channel, N cascaded integrators SHALL update only on pdm_en: I0 += x, Ik += I(k-1), all mod 2^W (wrap is legal, never saturate).
REQ-017 A decimation counter (0..R-1) SHALL increment on each pdm_en and wrap R-1 -> 0.
REQ-018 On the clk where pdm_en=1 and counter=R-1, the last integrator of every channel SHALL be captured (value including that sample) into a snapshot bank; this is a frame tick.
REQ-019 Combs SHALL be time-multiplexed: in the CH clocks after a frame tick, clock c processes channel c through N combs (Ck = C(k-1) - Dk, Dk <= C(k-1)), one channel per clock, mod 2^W.
REQ-020 Per-channel comb delay state SHALL update exactly once per frame tick, independent of dout_ready.
REQ-021 Comb result SHALL be reduced to OW bits by taking bits [W-1:W-OW] (truncate, no rounding) into an output buffer of CH words.
REQ-022 dout_valid SHALL rise on clk T+CH+1 (T = frame tick clk) presenting channel 0; channels SHALL be presented in ascending order 0..CH-1.
REQ-023 dout, dout_ch SHALL hold stable while dout_valid=1 and dout_ready=0; on handshake the next channel SHALL appear the following clk; after channel CH-1 handshake dout_valid SHALL drop.
REQ-024 dout_ready=1 continuously SHALL drain a frame in CH clocks, one sample per clk.
REQ-025 If a new frame's comb results complete while the previous frame is not fully drained, the buffer SHALL be overwritten, presentation SHALL restart at channel 0, and overrun SHALL set.
REQ-026 overrun SHALL clear only by reset.
REQ-027 pdm_en during comb processing SHALL still update integrators and counter normally.
REQ-028 pdm_en=0 SHALL freeze integrators and counter; output handshake SHALL continue.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear integrators, snapshot bank, comb and delay state, counter, output buffer, comb sequencer; dout=0, dout_ch=0, dout_valid=0, overrun=0.
REQ-030 Reset mid-frame or mid-drain SHALL discard all pending samples; first frame after release follows REQ-018 from counter 0.
REQ-031 Outputs of frames 1..N-1 after reset are transient; frame N onward SHALL be steady-state.

Verification (N=3, R=64, CH=2, OW=16, W=20, dout_ready=1 unless stated)
REQ-032 pdm_in=2'b11, pdm_en every clk -> from frame 3: dout=0x4000 on both channels, dout_ch 0 then 1.
REQ-033 ch0 all ones, ch1 all zeros -> from frame 3: ch0 dout=0x4000, ch1 dout=0xC000.
REQ-034 both channels alternating 1,0 -> from frame 3: dout=0x0000 both channels.
REQ-035 dout_ready=0 for 2*64 clks after frame tick -> dout held at channel 0, overrun=1 after second frame, channel 0 of newest frame presented.
REQ-036 rst_n low for 1 clk mid-drain -> dout_valid=0, overrun=0 immediately, next dout_valid exactly 64 pdm_en strobes plus 3 clks after release.
REQ-037 pdm_en asserted every 4th clk with constant ones -> identical samples to REQ-032, frame spacing 256 clks.
